// File: rtl/writeback_stage_if.sv
// Bundle of every non-clock signal crossing the writeback stage boundary:
// the memory-stage handoff, CSR counter writes, execute-stage forwarding
// lookups and the register-file / CSR outputs.

`ifndef ENCDEC_BYTE
`define ENCDEC_BYTE 2'd0
`endif
`ifndef ENCDEC_HALF
`define ENCDEC_HALF 2'd1
`endif
`ifndef ENCDEC_WORD
`define ENCDEC_WORD 2'd2
`endif

interface writeback_stage_if;
  logic        mb_wb__valid;
  logic        mb_wb__kill;
  logic        mb_wb__rd_write;
  logic [4:0]  mb_wb__rd_addr;
  logic        mb_wb__result_src;
  logic [31:0] mb_wb__alu_y;
  logic [1:0]  mb_wb__dmem_width;
  logic        mb_wb__dmem_zero_ext;
  logic [1:0]  mb_wb__dmem_word_addr;
  logic [31:0] mb_wb__dmem_rdata;

  logic [31:0] csr_wb__instret_wdata;
  logic        csr_wb__instret_write_lo;
  logic        csr_wb__instret_write_hi;

  logic [4:0]  ex_wb__rs1_addr;
  logic [4:0]  ex_wb__rs2_addr;

  logic        wb_rf__rd_write;
  logic [4:0]  wb_rf__rd_addr;
  logic [31:0] wb_rf__rd_wdata;

  logic        wb_ex__rs1_hit;
  logic        wb_ex__rs2_hit;
  logic [31:0] wb_ex__rs1_data;
  logic [31:0] wb_ex__rs2_data;

  logic [63:0] wb_csr__instret;

  // Surrounding pipeline side: drives instructions and lookups, reads results.
  modport master (
    output mb_wb__valid, mb_wb__kill, mb_wb__rd_write, mb_wb__rd_addr,
           mb_wb__result_src, mb_wb__alu_y, mb_wb__dmem_width,
           mb_wb__dmem_zero_ext, mb_wb__dmem_word_addr, mb_wb__dmem_rdata,
           csr_wb__instret_wdata, csr_wb__instret_write_lo, csr_wb__instret_write_hi,
           ex_wb__rs1_addr, ex_wb__rs2_addr,
    input  wb_rf__rd_write, wb_rf__rd_addr, wb_rf__rd_wdata,
           wb_ex__rs1_hit, wb_ex__rs2_hit, wb_ex__rs1_data, wb_ex__rs2_data,
           wb_csr__instret
  );

  // Writeback stage side.
  modport slave (
    input  mb_wb__valid, mb_wb__kill, mb_wb__rd_write, mb_wb__rd_addr,
           mb_wb__result_src, mb_wb__alu_y, mb_wb__dmem_width,
           mb_wb__dmem_zero_ext, mb_wb__dmem_word_addr, mb_wb__dmem_rdata,
           csr_wb__instret_wdata, csr_wb__instret_write_lo, csr_wb__instret_write_hi,
           ex_wb__rs1_addr, ex_wb__rs2_addr,
    output wb_rf__rd_write, wb_rf__rd_addr, wb_rf__rd_wdata,
           wb_ex__rs1_hit, wb_ex__rs2_hit, wb_ex__rs1_data, wb_ex__rs2_data,
           wb_csr__instret
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: decodes loads, registers the register-file write, keeps a
// two-deep forwarding history for the execute stage and counts retired
// instructions in a CSR-writable 64-bit counter.

module writeback_stage (
  input  logic               clk,
  input  logic               rst_n,
  writeback_stage_if.slave   bus
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] result;
  logic        retire;
  logic        rd_we_next;

  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;

  logic [63:0] instret_q;
  logic [63:0] instret_next;

  // Pick the addressed byte and halfword lanes out of the raw memory word
  always_comb begin
    load_byte = bus.mb_wb__dmem_rdata[7:0];
    case (bus.mb_wb__dmem_word_addr)
      2'd1:    load_byte = bus.mb_wb__dmem_rdata[15:8];
      2'd2:    load_byte = bus.mb_wb__dmem_rdata[23:16];
      2'd3:    load_byte = bus.mb_wb__dmem_rdata[31:24];
      default: load_byte = bus.mb_wb__dmem_rdata[7:0];
    endcase
    load_half = bus.mb_wb__dmem_word_addr[1] ? bus.mb_wb__dmem_rdata[31:16]
                                              : bus.mb_wb__dmem_rdata[15:0];
  end

  // Size and extend the load, then choose between load data and ALU result
  always_comb begin
    load_data = bus.mb_wb__dmem_rdata;
    case (bus.mb_wb__dmem_width)
      `ENCDEC_BYTE: load_data = {{24{~bus.mb_wb__dmem_zero_ext & load_byte[7]}}, load_byte};
      `ENCDEC_HALF: load_data = {{16{~bus.mb_wb__dmem_zero_ext & load_half[15]}}, load_half};
      `ENCDEC_WORD: load_data = bus.mb_wb__dmem_rdata;
      default:      load_data = bus.mb_wb__dmem_rdata;
    endcase
    result = bus.mb_wb__result_src ? load_data : bus.mb_wb__alu_y;
  end

  assign retire     = bus.mb_wb__valid & ~bus.mb_wb__kill;
  assign rd_we_next = retire & bus.mb_wb__rd_write & (bus.mb_wb__rd_addr != 5'd0);

  // Write stage register; address and data only move on a real write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_rf__rd_write <= 1'b0;
      bus.wb_rf__rd_addr  <= 5'd0;
      bus.wb_rf__rd_wdata <= 32'd0;
    end else begin
      bus.wb_rf__rd_write <= rd_we_next;
      if (rd_we_next) begin
        bus.wb_rf__rd_addr  <= bus.mb_wb__rd_addr;
        bus.wb_rf__rd_wdata <= result;
      end
    end
  end

  // Older forwarding entry trails the write stage register by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_addr  <= 5'd0;
      b_data  <= 32'd0;
    end else begin
      b_valid <= bus.wb_rf__rd_write;
      b_addr  <= bus.wb_rf__rd_addr;
      b_data  <= bus.wb_rf__rd_wdata;
    end
  end

  // Returns {hit, data}; the younger entry wins when both match
  function automatic logic [32:0] fwd_lookup(
    input logic [4:0]  addr,
    input logic        a_v,
    input logic [4:0]  a_a,
    input logic [31:0] a_d,
    input logic        b_v,
    input logic [4:0]  b_a,
    input logic [31:0] b_d
  );
    logic [32:0] r;
    r = 33'd0;
    if (addr != 5'd0) begin
      if (a_v && (a_a == addr))      r = {1'b1, a_d};
      else if (b_v && (b_a == addr)) r = {1'b1, b_d};
    end
    return r;
  endfunction

  // Forwarding lookup for rs1
  always_comb begin
    {bus.wb_ex__rs1_hit, bus.wb_ex__rs1_data} =
      fwd_lookup(bus.ex_wb__rs1_addr, bus.wb_rf__rd_write, bus.wb_rf__rd_addr,
                 bus.wb_rf__rd_wdata, b_valid, b_addr, b_data);
  end

  // Forwarding lookup for rs2
  always_comb begin
    {bus.wb_ex__rs2_hit, bus.wb_ex__rs2_data} =
      fwd_lookup(bus.ex_wb__rs2_addr, bus.wb_rf__rd_write, bus.wb_rf__rd_addr,
                 bus.wb_rf__rd_wdata, b_valid, b_addr, b_data);
  end

  // Next counter value: any CSR write owns the whole counter for that edge
  always_comb begin
    instret_next = instret_q;
    if (bus.csr_wb__instret_write_lo || bus.csr_wb__instret_write_hi) begin
      if (bus.csr_wb__instret_write_lo) instret_next[31:0]  = bus.csr_wb__instret_wdata;
      if (bus.csr_wb__instret_write_hi) instret_next[63:32] = bus.csr_wb__instret_wdata;
    end else if (retire) begin
      instret_next = instret_q + 64'd1;
    end
  end

  // Retired-instruction counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= 64'd0;
    else        instret_q <= instret_next;
  end

  assign bus.wb_csr__instret = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed cases for load decode, x0/kill,
// forwarding priority, counter carry/precedence and async reset, followed by
// randomized traffic compared against a behavioural model.

module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic        kill;
    logic        rd_write;
    logic [4:0]  rd_addr;
    logic        result_src;
    logic [31:0] alu_y;
    logic [1:0]  width;
    logic        zero_ext;
    logic [1:0]  word_addr;
    logic [31:0] rdata;
    logic [31:0] csr_wdata;
    logic        csr_lo;
    logic        csr_hi;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } stim_t;

  int checks = 0;
  int errors = 0;

  // Model state: entry 0 is the newest register-file write, entry 1 the one before
  logic        ent_valid [2];
  logic [4:0]  ent_addr  [2];
  logic [31:0] ent_data  [2];
  logic [63:0] m_instret;

  function automatic stim_t idleStim();
    stim_t s;
    s.valid = 0; s.kill = 0; s.rd_write = 0; s.rd_addr = 0; s.result_src = 0;
    s.alu_y = 0; s.width = 2; s.zero_ext = 0; s.word_addr = 0; s.rdata = 0;
    s.csr_wdata = 0; s.csr_lo = 0; s.csr_hi = 0; s.rs1 = 0; s.rs2 = 0;
    return s;
  endfunction

  // Load value from plain shift-and-mask arithmetic on the raw word
  function automatic logic [31:0] modelLoad(input logic [1:0] width, input logic zext,
                                            input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] raw;
    if (width == 2'd0) begin
      raw = (rdata >> (8 * off)) & 32'h0000_00FF;
      if (!zext && raw[7]) raw = raw | 32'hFFFF_FF00;
    end else if (width == 2'd1) begin
      raw = (rdata >> (16 * off[1])) & 32'h0000_FFFF;
      if (!zext && raw[15]) raw = raw | 32'hFFFF_0000;
    end else begin
      raw = rdata;
    end
    return raw;
  endfunction

  task automatic modelLookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 0;
    d = 0;
    if (a != 0) begin
      for (int k = 1; k >= 0; k--) begin
        if (ent_valid[k] && ent_addr[k] == a) begin
          hit = 1;
          d = ent_data[k];
        end
      end
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      ent_valid[k] = 0;
      ent_addr[k] = 0;
      ent_data[k] = 0;
    end
    m_instret = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    logic h1, h2;
    logic [31:0] d1, d2;
    modelLookup(bus.ex_wb__rs1_addr, h1, d1);
    modelLookup(bus.ex_wb__rs2_addr, h2, d2);
    checkOutput({tag, " rd_write"}, 64'(bus.wb_rf__rd_write), 64'(ent_valid[0]));
    checkOutput({tag, " rd_addr"},  64'(bus.wb_rf__rd_addr),  64'(ent_addr[0]));
    checkOutput({tag, " rd_wdata"}, 64'(bus.wb_rf__rd_wdata), 64'(ent_data[0]));
    checkOutput({tag, " instret"},  bus.wb_csr__instret,      m_instret);
    checkOutput({tag, " rs1_hit"},  64'(bus.wb_ex__rs1_hit),  64'(h1));
    checkOutput({tag, " rs1_data"}, 64'(bus.wb_ex__rs1_data), 64'(d1));
    checkOutput({tag, " rs2_hit"},  64'(bus.wb_ex__rs2_hit),  64'(h2));
    checkOutput({tag, " rs2_data"}, 64'(bus.wb_ex__rs2_data), 64'(d2));
  endtask

  // Drive one instruction, advance one clock and check everything after the edge
  task automatic applyStimulus(input stim_t s, input string tag);
    logic        retire, we;
    logic [31:0] res;
    logic [63:0] nxt;
    bus.mb_wb__valid          = s.valid;
    bus.mb_wb__kill           = s.kill;
    bus.mb_wb__rd_write       = s.rd_write;
    bus.mb_wb__rd_addr        = s.rd_addr;
    bus.mb_wb__result_src     = s.result_src;
    bus.mb_wb__alu_y          = s.alu_y;
    bus.mb_wb__dmem_width     = s.width;
    bus.mb_wb__dmem_zero_ext  = s.zero_ext;
    bus.mb_wb__dmem_word_addr = s.word_addr;
    bus.mb_wb__dmem_rdata     = s.rdata;
    bus.csr_wb__instret_wdata    = s.csr_wdata;
    bus.csr_wb__instret_write_lo = s.csr_lo;
    bus.csr_wb__instret_write_hi = s.csr_hi;
    bus.ex_wb__rs1_addr       = s.rs1;
    bus.ex_wb__rs2_addr       = s.rs2;

    retire = s.valid && !s.kill;
    we = retire && s.rd_write && (s.rd_addr != 0);
    res = s.result_src ? modelLoad(s.width, s.zero_ext, s.word_addr, s.rdata) : s.alu_y;
    nxt = m_instret;
    if (s.csr_lo || s.csr_hi) begin
      if (s.csr_lo) nxt = {nxt[63:32], s.csr_wdata};
      if (s.csr_hi) nxt = {s.csr_wdata, nxt[31:0]};
    end else if (retire) begin
      nxt = m_instret + 1;
    end

    @(posedge clk);
    ent_valid[1] = ent_valid[0];
    ent_addr[1]  = ent_addr[0];
    ent_data[1]  = ent_data[0];
    ent_valid[0] = we;
    if (we) begin
      ent_addr[0] = s.rd_addr;
      ent_data[0] = res;
    end
    m_instret = nxt;
    @(negedge clk);
    checkAll(tag);
  endtask

  stim_t s;
  logic [63:0] saved;

  initial begin
    modelReset();
    s = idleStim();
    bus.mb_wb__valid = 0; bus.mb_wb__kill = 0; bus.mb_wb__rd_write = 0;
    bus.mb_wb__rd_addr = 0; bus.mb_wb__result_src = 0; bus.mb_wb__alu_y = 0;
    bus.mb_wb__dmem_width = 2; bus.mb_wb__dmem_zero_ext = 0;
    bus.mb_wb__dmem_word_addr = 0; bus.mb_wb__dmem_rdata = 0;
    bus.csr_wb__instret_wdata = 0; bus.csr_wb__instret_write_lo = 0;
    bus.csr_wb__instret_write_hi = 0; bus.ex_wb__rs1_addr = 0; bus.ex_wb__rs2_addr = 0;

    // Reset state
    #3;
    checkAll("reset");
    checkOutput("reset no X", 64'($isunknown({bus.wb_rf__rd_write, bus.wb_rf__rd_addr,
                bus.wb_rf__rd_wdata, bus.wb_ex__rs1_hit, bus.wb_ex__rs1_data,
                bus.wb_ex__rs2_hit, bus.wb_ex__rs2_data, bus.wb_csr__instret})), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Byte load, sign extended
    s = idleStim();
    s.valid = 1; s.rd_write = 1; s.rd_addr = 5; s.result_src = 1; s.alu_y = 32'hDEAD_BEEF;
    s.width = 0; s.zero_ext = 0; s.word_addr = 2; s.rdata = 32'h1280_3456; s.rs1 = 5;
    applyStimulus(s, "byte sext");
    checkOutput("byte sext we", 64'(bus.wb_rf__rd_write), 64'd1);
    checkOutput("byte sext addr", 64'(bus.wb_rf__rd_addr), 64'd5);
    checkOutput("byte sext wdata", 64'(bus.wb_rf__rd_wdata), 64'hFFFF_FF80);

    // Half load, zero then sign extended
    s = idleStim();
    s.valid = 1; s.rd_write = 1; s.rd_addr = 6; s.result_src = 1;
    s.width = 1; s.zero_ext = 1; s.word_addr = 2; s.rdata = 32'h8001_1234;
    applyStimulus(s, "half zext");
    checkOutput("half zext wdata", 64'(bus.wb_rf__rd_wdata), 64'h0000_8001);
    s.zero_ext = 0;
    applyStimulus(s, "half sext");
    checkOutput("half sext wdata", 64'(bus.wb_rf__rd_wdata), 64'hFFFF_8001);

    // x0 destination still retires but never writes or forwards
    saved = bus.wb_csr__instret;
    s = idleStim();
    s.valid = 1; s.rd_write = 1; s.rd_addr = 0; s.alu_y = 32'h55;
    applyStimulus(s, "x0 write");
    checkOutput("x0 we", 64'(bus.wb_rf__rd_write), 64'd0);
    checkOutput("x0 hit", 64'(bus.wb_ex__rs1_hit), 64'd0);
    checkOutput("x0 instret", bus.wb_csr__instret, saved + 64'd1);

    // Killed instruction neither writes nor counts
    saved = bus.wb_csr__instret;
    s = idleStim();
    s.valid = 1; s.kill = 1; s.rd_write = 1; s.rd_addr = 3; s.alu_y = 32'h77;
    applyStimulus(s, "kill");
    checkOutput("kill we", 64'(bus.wb_rf__rd_write), 64'd0);
    checkOutput("kill instret", bus.wb_csr__instret, saved);

    // Forwarding priority: newest write to x7 wins, then ages out
    s = idleStim();
    s.valid = 1; s.rd_write = 1; s.rd_addr = 7; s.alu_y = 32'hA; s.rs1 = 7;
    applyStimulus(s, "fwd first");
    s.alu_y = 32'hB;
    applyStimulus(s, "fwd second");
    checkOutput("fwd pri hit", 64'(bus.wb_ex__rs1_hit), 64'd1);
    checkOutput("fwd pri data", 64'(bus.wb_ex__rs1_data), 64'hB);
    s = idleStim();
    s.rs1 = 7;
    applyStimulus(s, "fwd idle1");
    checkOutput("fwd idle1 data", 64'(bus.wb_ex__rs1_data), 64'hB);
    applyStimulus(s, "fwd idle2");
    checkOutput("fwd aged hit", 64'(bus.wb_ex__rs1_hit), 64'd0);

    // Counter carry into the upper half
    s = idleStim();
    s.csr_lo = 1; s.csr_wdata = 32'hFFFF_FFFF;
    applyStimulus(s, "csr lo");
    s = idleStim();
    s.csr_hi = 1; s.csr_wdata = 32'h0;
    applyStimulus(s, "csr hi");
    s = idleStim();
    s.valid = 1;
    applyStimulus(s, "carry");
    checkOutput("carry value", bus.wb_csr__instret, 64'h0000_0001_0000_0000);

    // CSR write beats a same-cycle retire
    s = idleStim();
    s.valid = 1; s.csr_lo = 1; s.csr_wdata = 32'h10;
    applyStimulus(s, "csr precedence");
    checkOutput("csr precedence value", bus.wb_csr__instret, 64'h0000_0001_0000_0010);

    // Both halves written together, then wrap to zero
    s = idleStim();
    s.csr_lo = 1; s.csr_hi = 1; s.csr_wdata = 32'hFFFF_FFFF;
    applyStimulus(s, "csr both");
    s = idleStim();
    s.valid = 1;
    applyStimulus(s, "wrap");
    checkOutput("wrap value", bus.wb_csr__instret, 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      s.valid      = ($urandom_range(0, 3) != 0);
      s.kill       = ($urandom_range(0, 4) == 0);
      s.rd_write   = ($urandom_range(0, 5) != 0);
      s.rd_addr    = 5'($urandom_range(0, 7));
      s.result_src = 1'($urandom_range(0, 1));
      s.alu_y      = $urandom;
      s.width      = 2'($urandom_range(0, 3));
      s.zero_ext   = 1'($urandom_range(0, 1));
      s.word_addr  = 2'($urandom_range(0, 3));
      s.rdata      = $urandom;
      s.csr_wdata  = $urandom;
      s.csr_lo     = ($urandom_range(0, 19) == 0);
      s.csr_hi     = ($urandom_range(0, 19) == 0);
      s.rs1        = 5'($urandom_range(0, 7));
      s.rs2        = 5'($urandom_range(0, 7));
      applyStimulus(s, "random");
    end

    // Asynchronous reset between edges discards the in-flight write
    s = idleStim();
    s.valid = 1; s.rd_write = 1; s.rd_addr = 9; s.alu_y = 32'h1234_5678; s.rs1 = 9;
    applyStimulus(s, "pre reset");
    checkOutput("pre reset we", 64'(bus.wb_rf__rd_write), 64'd1);
    #2;
    rst_n = 0;
    #1;
    modelReset();
    checkOutput("async reset we", 64'(bus.wb_rf__rd_write), 64'd0);
    checkOutput("async reset instret", bus.wb_csr__instret, 64'd0);
    checkOutput("async reset rs1_hit", 64'(bus.wb_ex__rs1_hit), 64'd0);
    checkAll("async reset");
    @(negedge clk);
    rst_n = 1;

    // Fresh pipeline after reset release
    for (int i = 0; i < 40; i++) begin
      s.valid      = ($urandom_range(0, 3) != 0);
      s.kill       = ($urandom_range(0, 4) == 0);
      s.rd_write   = 1'b1;
      s.rd_addr    = 5'($urandom_range(0, 3));
      s.result_src = 1'($urandom_range(0, 1));
      s.alu_y      = $urandom;
      s.width      = 2'($urandom_range(0, 2));
      s.zero_ext   = 1'($urandom_range(0, 1));
      s.word_addr  = 2'($urandom_range(0, 3));
      s.rdata      = $urandom;
      s.csr_lo     = 0;
      s.csr_hi     = 0;
      s.rs1        = 5'($urandom_range(0, 3));
      s.rs2        = 5'($urandom_range(0, 3));
      applyStimulus(s, "post reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL expose these ports; all inputs are sampled on the rising edge of clk:
- clk  in  1  single clock for all state.
- rst_n  in  1  asynchronous active-low reset.
- mb_wb__valid  in  1  an instruction is presented this cycle.
- mb_wb__kill  in  1  the presented instruction trapped and SHALL NOT retire.
- mb_wb__rd_write  in  1  the instruction writes rd.
- mb_wb__rd_addr  in  5  destination register.
- mb_wb__result_src  in  1  0 = ALU result, 1 = load data.
- mb_wb__alu_y  in  32  ALU result.
- mb_wb__dmem_width  in  2  `ENCDEC_BYTE, `ENCDEC_HALF or `ENCDEC_WORD.
- mb_wb__dmem_zero_ext  in  1  1 = zero-extend the load, 0 = sign-extend.
- mb_wb__dmem_word_addr  in  2  byte offset of the load within the word.
- mb_wb__dmem_rdata  in  32  raw data-memory word, valid in the same cycle as the fields above.
- csr_wb__instret_wdata  in  32  CSR write data for the retire counter.
- csr_wb__instret_write_lo / csr_wb__instret_write_hi  in  1 each  write [31:0] / [63:32] of the counter.
- ex_wb__rs1_addr / ex_wb__rs2_addr  in  5 each  forwarding lookup addresses.
- wb_rf__rd_write  out  1  register-file write enable.
- wb_rf__rd_addr  out  5  register-file write address.
- wb_rf__rd_wdata  out  32  register-file write data.
- wb_ex__rs1_hit / wb_ex__rs2_hit  out  1 each  forwarding hit.
- wb_ex__rs1_data / wb_ex__rs2_data  out  32 each  forwarded data.
- wb_csr__instret  out  64  retired-instruction counter.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-003 Load decode SHALL be combinational on the mb_wb__ inputs:
- byte: lane = word_addr, data = rdata[8*lane+7 : 8*lane].
- half: lane = word_addr[1], data = rdata[16*lane+15 : 16*lane].
- word: data = rdata unmodified.
- extension follows dmem_zero_ext.
REQ-004 Result = decoded load data when result_src = 1, otherwise alu_y.
REQ-005 retire = mb_wb__valid && !mb_wb__kill.
REQ-006 Write stage (1-cycle latency) on each clock edge:
- wb_rf__rd_write <= retire && rd_write && (rd_addr != 0).
- wb_rf__rd_addr <= rd_addr; wb_rf__rd_wdata <= result.
- rd_addr and rd_wdata SHALL hold their values when wb_rf__rd_write = 0.
REQ-007 A write to x0 SHALL never assert wb_rf__rd_write and SHALL never create a forwarding entry.
REQ-008 Forwarding history SHALL be two entries deep:
- entry A = the current wb_rf write; entry B = the previous wb_rf write, each with its own valid bit.
- A shifts into B on every clock edge; A valid = wb_rf__rd_write.
REQ-009 Forwarding lookup SHALL be combinational:
- rsN_hit = 1 when rsN_addr != 0 and it matches a valid entry.
- on a double match, entry A wins.
- rsN_data = the matching entry's data, otherwise 0.
REQ-010 Retire counter is 64-bit:
- increments by 1 on each edge where retire = 1.
- wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-011 CSR writes to the counter:
- write_lo replaces [31:0]; write_hi replaces [63:32].
- both asserted: both halves are written from the same data.
- a CSR write in a cycle SHALL take precedence over that cycle's increment for the whole counter.
REQ-012 Carry from [31:0] into [63:32] SHALL take effect in the same edge as the increment.
REQ-013 mb_wb__kill with mb_wb__valid = 0 SHALL have no effect.

Reset
REQ-014 While rst_n = 0, the following SHALL be 0 and SHALL take effect immediately, without a clock edge:
- wb_rf__rd_write, wb_rf__rd_addr, wb_rf__rd_wdata.
- both forwarding valid bits.
- wb_csr__instret.
REQ-015 Reset asserted mid-stream SHALL discard the in-flight write; the first edge after release SHALL behave as a fresh pipeline.
REQ-016 No output SHALL be X after reset.

Verification
REQ-017 Byte load sign-extend: width = BYTE, word_addr = 2, zero_ext = 0, rdata = 0x12_80_34_56, rd = 5 -> next cycle wb_rf__rd_write = 1, addr = 5, wdata = 0xFFFF_FF80.
REQ-018 Half load zero-extend: width = HALF, word_addr = 2, zero_ext = 1, rdata = 0x8001_1234 -> wdata = 0x0000_8001; same with zero_ext = 0 -> 0xFFFF_8001.
REQ-019 x0 and kill:
- valid, rd = 0, ALU result 0x55 -> no write, no hit, instret +1.
- valid with kill = 1, rd = 3 -> no write, instret unchanged.
REQ-020 Forwarding priority: back-to-back retires to x7 with 0xA then 0xB, rs1_addr = 7 -> the cycle after the second write, rs1_hit = 1, rs1_data = 0xB; after two idle cycles rs1_hit = 0.
REQ-021 Counter carry and precedence:
- instret = 0x0000_0000_FFFF_FFFF plus one retire -> 0x0000_0001_0000_0000.
- write_lo = 0x10 in the same cycle as a retire -> [31:0] = 0x10, no increment.
REQ-022 Asynchronous reset mid-operation: rst_n low between clock edges while wb_rf__rd_write = 1 -> write enable and instret read 0 before the next edge.
